// File: rtl/hazard_scheduler_if.sv
// Hazard scheduler bundle: pipeline register ids, control bits,
// stall/flush/forward controls (StallCount with HAZARD_SCHEDULER_PERF_CNT_EN).
interface hazard_scheduler_if #(
  parameter int REG_ADDR = 5
);
  logic [REG_ADDR-1:0] RsD, RtD, RsE, RtE;
  logic [REG_ADDR-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW;
  logic MemtoRegE, MemtoRegM;
  logic BranchD, PCSrcTakenD, MulE;
  logic StallF, StallD, StallE;
  logic FlushD, FlushE, FlushM;
  logic ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic MulBusy;
`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
  logic [31:0] StallCount;
`endif

  modport master (
    output RsD, RtD, RsE, RtE,
    output WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW,
    output MemtoRegE, MemtoRegM,
    output BranchD, PCSrcTakenD, MulE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  ForwardAD, ForwardBD,
    input  ForwardAE, ForwardBE,
`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
    input  StallCount,
`endif
    input  MulBusy
  );

  modport slave (
    input  RsD, RtD, RsE, RtE,
    input  WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW,
    input  MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcTakenD, MulE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output ForwardAD, ForwardBD,
    output ForwardAE, ForwardBE,
`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
    output StallCount,
`endif
    output MulBusy
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline hazard unit: forwarding, load-use/branch stalls, multiply
// sequencer. Ports: CLK, RST, hz (slave). Macro HAZARD_SCHEDULER_PERF_CNT_EN.
module hazard_scheduler #(
  parameter int REG_ADDR = 5,
  parameter int MUL_LAT  = 4
) (
  input logic CLK,
  input logic RST,
  hazard_scheduler_if.slave hz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LOAD = 4'(MUL_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lw, br, mul_stall;
  logic       stall_f;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic hit(
    input logic [REG_ADDR-1:0] a,
    input logic [REG_ADDR-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    lw = hz.MemtoRegE &
         (hit(hz.RtE, hz.RsD) | hit(hz.RtE, hz.RtD));
    br = hz.BranchD &
         ((hz.RegWriteE &
           (hit(hz.WriteRegE, hz.RsD) |
            hit(hz.WriteRegE, hz.RtD))) |
          (hz.MemtoRegM &
           (hit(hz.WriteRegM, hz.RsD) |
            hit(hz.WriteRegM, hz.RtD))));
    mul_stall = hz.MulE && (state_q != DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE cycle plus the RUN cycles form the MUL_LAT-1 stalled
  // cycles; DONE is the final, unstalled Execute cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.MulE) begin
          state_d = RUN;
          cnt_d   = LOAD;
        end
      end
      RUN: begin
        // Leave once the decremented count reaches 0.
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.MulBusy   = 1'b0;
    if (!RST) begin
      if (hz.RegWriteM && hit(hz.WriteRegM, hz.RsE))
        hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && hit(hz.WriteRegW, hz.RsE))
        hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && hit(hz.WriteRegM, hz.RtE))
        hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && hit(hz.WriteRegW, hz.RtE))
        hz.ForwardBE = 2'b01;
      hz.ForwardAD = hz.RegWriteM & hit(hz.WriteRegM, hz.RsD);
      hz.ForwardBD = hz.RegWriteM & hit(hz.WriteRegM, hz.RtD);
      if (mul_stall) begin
        // Hold Execute; bubble what would leave it.
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else if (lw || br) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
      hz.FlushD  = hz.PCSrcTakenD & ~hz.StallD;
      hz.MulBusy = (state_q != IDLE);
    end
  end

  assign stall_f = hz.StallF;

`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stall_cnt_q <= '0;
    else if (stall_f && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.StallCount = stall_cnt_q;
`else
  logic unused_stall_f;
  assign unused_stall_f = stall_f;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: forwarding, stalls,
// multiply sequencing and reset behaviour.
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_scheduler_if #(.REG_ADDR(5)) bus ();

  hazard_scheduler #(
    .REG_ADDR(5),
    .MUL_LAT (4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .hz (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] vec();
    return {bus.StallF, bus.StallD, bus.StallE,
            bus.FlushD, bus.FlushE, bus.FlushM};
  endfunction

  task automatic clr();
    bus.RsD = '0; bus.RtD = '0; bus.RsE = '0; bus.RtE = '0;
    bus.WriteRegE = '0; bus.WriteRegM = '0; bus.WriteRegW = '0;
    bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemtoRegE = 0; bus.MemtoRegM = 0;
    bus.BranchD = 0; bus.PCSrcTakenD = 0; bus.MulE = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b2b_exp;

  initial begin
    clr();
    // reset forces everything low even with active inputs
    bus.MemtoRegE = 1; bus.RtE = 3; bus.RsD = 3;
    bus.RegWriteM = 1; bus.WriteRegM = 5; bus.RsE = 5;
    bus.PCSrcTakenD = 1; bus.MulE = 1;
    #1;
    chk("rst_vec", 32'(vec()), 32'h0);
    chk("rst_fwdae", 32'(bus.ForwardAE), 32'h0);
    chk("rst_busy", 32'(bus.MulBusy), 32'h0);
    step();
    rst = 0;
    clr();

    // memory beats writeback
    bus.RegWriteM = 1; bus.WriteRegM = 5; bus.RsE = 5;
    bus.RegWriteW = 1; bus.WriteRegW = 5;
    #1;
    chk("fwd_m_over_w", 32'(bus.ForwardAE), 32'h2);
    chk("fwd_be_idle", 32'(bus.ForwardBE), 32'h0);
    bus.RegWriteM = 0;
    #1;
    chk("fwd_w", 32'(bus.ForwardAE), 32'h1);
    bus.RsE = 0; bus.WriteRegW = 0;
    bus.RegWriteM = 1; bus.WriteRegM = 0;
    #1;
    chk("fwd_r0", 32'(bus.ForwardAE), 32'h0);
    bus.RtE = 7; bus.WriteRegM = 7;
    #1;
    chk("fwd_be_m", 32'(bus.ForwardBE), 32'h2);
    bus.RsD = 9; bus.WriteRegM = 9;
    #1;
    chk("fwd_ad", 32'(bus.ForwardAD), 32'h1);
    chk("fwd_bd", 32'(bus.ForwardBD), 32'h0);

    // load-use
    step(); clr();
    bus.MemtoRegE = 1; bus.RtE = 3; bus.RsD = 3;
    #1;
    chk("lw_stall", 32'(vec()), 32'b110010);
    step(); clr();
    #1;
    chk("lw_gone", 32'(vec()), 32'h0);
    bus.MemtoRegE = 1; bus.WriteRegE = 0; bus.RtE = 0;
    #1;
    chk("lw_r0", 32'(vec()), 32'h0);

    // branch hazards
    step(); clr();
    bus.BranchD = 1; bus.RegWriteE = 1;
    bus.WriteRegE = 4; bus.RtD = 4;
    #1;
    chk("br_e", 32'(vec()), 32'b110010);
    step(); clr();
    bus.BranchD = 1; bus.MemtoRegM = 1;
    bus.WriteRegM = 6; bus.RsD = 6;
    #1;
    chk("br_m", 32'(vec()), 32'b110010);

    // taken branch flush, suppressed by stall
    step(); clr();
    bus.PCSrcTakenD = 1;
    #1;
    chk("flushd", 32'(vec()), 32'b000100);
    bus.MemtoRegE = 1; bus.RtE = 2; bus.RtD = 2;
    #1;
    chk("flushd_stall", 32'(vec()), 32'b110010);

    // clean counter state before the multiply
    step(); clr();
    rst = 1;
    #1;
`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
    chk("cnt_rst", bus.StallCount, 32'h0);
`endif
    step();
    rst = 0;

    // single multiply, MUL_LAT=4; lw also present, mul wins
    bus.MulE = 1;
    bus.MemtoRegE = 1; bus.RtE = 3; bus.RsD = 3;
    #1;
    chk("mul_c1", 32'(vec()), 32'b111001);
    chk("mul_c1_busy", 32'(bus.MulBusy), 32'h0);
    step();
    chk("mul_c2", 32'(vec()), 32'b111001);
    chk("mul_c2_busy", 32'(bus.MulBusy), 32'h1);
    step();
    chk("mul_c3", 32'(vec()), 32'b111001);
    chk("mul_c3_busy", 32'(bus.MulBusy), 32'h1);
    step();
    bus.MemtoRegE = 0;
    #1;
    chk("mul_done", 32'(vec()), 32'h0);
    chk("mul_done_busy", 32'(bus.MulBusy), 32'h1);
`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
    chk("cnt_mul", bus.StallCount, 32'd3);
`endif
    step();
    bus.MulE = 0;
    #1;
    chk("mul_idle_busy", 32'(bus.MulBusy), 32'h0);
    chk("mul_idle", 32'(vec()), 32'h0);

    // back-to-back multiplies
    step();
    bus.MulE = 1;
    b2b_exp = 8'b11101110;
    for (int i = 7; i >= 0; i--) begin
      #1;
      chk($sformatf("b2b_%0d", 7 - i),
          32'(bus.StallE), 32'(b2b_exp[i]));
      step();
    end
    bus.MulE = 0;

    // reset during the second RUN cycle
    step();
    bus.MulE = 1;
    step();
    step();
    #1;
    chk("rr_pre", 32'(vec()), 32'b111001);
    rst = 1;
    #1;
    chk("rr_vec", 32'(vec()), 32'h0);
    chk("rr_busy", 32'(bus.MulBusy), 32'h0);
`ifdef HAZARD_SCHEDULER_PERF_CNT_EN
    chk("rr_cnt", bus.StallCount, 32'h0);
`endif
    step();
    rst = 0;
    #1;
    chk("rr_c1", 32'(vec()), 32'b111001);
    chk("rr_c1_busy", 32'(bus.MulBusy), 32'h0);
    step();
    chk("rr_c2", 32'(vec()), 32'b111001);
    step();
    chk("rr_c3", 32'(vec()), 32'b111001);
    step();
    chk("rr_done", 32'(vec()), 32'h0);
    chk("rr_done_busy", 32'(bus.MulBusy), 32'h1);
    bus.MulE = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
